// File: rtl/score_argmax_reader_pkg.sv
// Shared types and constants for the classifier score argmax reader.
package score_argmax_reader_pkg;

  localparam int DATA_W      = 16;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;

  localparam logic signed [DATA_W-1:0] SCORE_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SCAN    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Winner minus runner-up, formed over DATA_W+1 bits. The running best
  // never drops below the runner-up, so the low DATA_W bits hold the
  // exact unsigned difference.
  function automatic logic [DATA_W-1:0] calc_margin(
    input logic signed [DATA_W-1:0] best,
    input logic signed [DATA_W-1:0] second
  );
    return DATA_W'({best[DATA_W-1], best} - {second[DATA_W-1], second});
  endfunction

endpackage

// File: rtl/score_argmax_reader_if.sv
// Result handshake bundle: winning index, its score and margin, valid/ready.
interface score_argmax_reader_if import score_argmax_reader_pkg::*; ();

  logic                     result_valid;
  logic                     result_ready;
  logic [IDX_W-1:0]         class_idx;
  logic signed [DATA_W-1:0] max_score;
  logic [DATA_W-1:0]        margin;

  modport master (
    output result_valid, class_idx, max_score, margin,
    input  result_ready
  );

  modport slave (
    input  result_valid, class_idx, max_score, margin,
    output result_ready
  );

endinterface

// File: rtl/score_argmax_reader_max_update.sv
// One step of the running max / runner-up tracker. Strict compare keeps the
// lowest index on ties.
module score_argmax_reader_max_update
  import score_argmax_reader_pkg::*;
(
  input  logic signed [DATA_W-1:0] best,
  input  logic signed [DATA_W-1:0] second,
  input  logic [IDX_W-1:0]         best_idx,
  input  logic signed [DATA_W-1:0] cand,
  input  logic [IDX_W-1:0]         cand_idx,
  output logic signed [DATA_W-1:0] best_nxt,
  output logic signed [DATA_W-1:0] second_nxt,
  output logic [IDX_W-1:0]         best_idx_nxt
);

  // Fold one candidate into the (best, second, best_idx) triple.
  always_comb begin
    best_nxt     = best;
    second_nxt   = second;
    best_idx_nxt = best_idx;
    if (cand > best) begin
      second_nxt   = best;
      best_nxt     = cand;
      best_idx_nxt = cand_idx;
    end else if (cand > second) begin
      second_nxt = cand;
    end else begin
      second_nxt = second;
    end
  end

endmodule

// File: rtl/score_argmax_reader.sv
// Waits for the layer-3 enable edge, settles, snapshots the ten class scores,
// scans them one per cycle and presents the argmax on a valid/ready port.
module score_argmax_reader
  import score_argmax_reader_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
)
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enableLayer3,
  input  logic signed [DATA_W-1:0] score0,
  input  logic signed [DATA_W-1:0] score1,
  input  logic signed [DATA_W-1:0] score2,
  input  logic signed [DATA_W-1:0] score3,
  input  logic signed [DATA_W-1:0] score4,
  input  logic signed [DATA_W-1:0] score5,
  input  logic signed [DATA_W-1:0] score6,
  input  logic signed [DATA_W-1:0] score7,
  input  logic signed [DATA_W-1:0] score8,
  input  logic signed [DATA_W-1:0] score9,
  output logic                     busy,
  score_argmax_reader_if.master    res
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_CLASSES - 1);

  state_t                   state_r;
  logic                     enable_q_r;
  logic [3:0]               settle_cnt_r;
  logic [IDX_W-1:0]         idx_r;
  logic signed [DATA_W-1:0] snap_r [NUM_CLASSES];
  logic signed [DATA_W-1:0] best_r;
  logic signed [DATA_W-1:0] second_r;
  logic [IDX_W-1:0]         best_idx_r;
  logic                     result_valid_r;
  logic [IDX_W-1:0]         class_idx_r;
  logic signed [DATA_W-1:0] max_score_r;
  logic [DATA_W-1:0]        margin_r;
  logic                     busy_r;

  logic                     rise_s;
  logic signed [DATA_W-1:0] score_in_s [NUM_CLASSES];
  logic signed [DATA_W-1:0] best_nxt_s;
  logic signed [DATA_W-1:0] second_nxt_s;
  logic [IDX_W-1:0]         best_idx_nxt_s;

  assign rise_s     = enableLayer3 & ~enable_q_r;
  assign score_in_s = '{score0, score1, score2, score3, score4,
                        score5, score6, score7, score8, score9};

  assign res.result_valid = result_valid_r;
  assign res.class_idx    = class_idx_r;
  assign res.max_score    = max_score_r;
  assign res.margin       = margin_r;
  assign busy             = busy_r;

  score_argmax_reader_max_update u_max_update (
    .best         (best_r),
    .second       (second_r),
    .best_idx     (best_idx_r),
    .cand         (snap_r[idx_r]),
    .cand_idx     (idx_r),
    .best_nxt     (best_nxt_s),
    .second_nxt   (second_nxt_s),
    .best_idx_nxt (best_idx_nxt_s)
  );

  // Control FSM with snapshot, scan accumulators and registered result port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      enable_q_r     <= 1'b0;
      settle_cnt_r   <= 4'd0;
      idx_r          <= {IDX_W{1'b0}};
      best_r         <= {DATA_W{1'b0}};
      second_r       <= {DATA_W{1'b0}};
      best_idx_r     <= {IDX_W{1'b0}};
      result_valid_r <= 1'b0;
      class_idx_r    <= {IDX_W{1'b0}};
      max_score_r    <= {DATA_W{1'b0}};
      margin_r       <= {DATA_W{1'b0}};
      busy_r         <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        snap_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      enable_q_r <= enableLayer3;
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            busy_r       <= 1'b1;
            settle_cnt_r <= 4'd0;
            state_r      <= (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            state_r <= ST_CAPTURE;
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        ST_CAPTURE: begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            snap_r[i] <= score_in_s[i];
          end
          best_r     <= score_in_s[0];
          best_idx_r <= {IDX_W{1'b0}};
          second_r   <= SCORE_MIN;
          idx_r      <= IDX_W'(1);
          state_r    <= ST_SCAN;
        end
        ST_SCAN: begin
          best_r     <= best_nxt_s;
          second_r   <= second_nxt_s;
          best_idx_r <= best_idx_nxt_s;
          if (idx_r == IDX_LAST) begin
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (!result_valid_r) begin
            class_idx_r    <= best_idx_r;
            max_score_r    <= best_r;
            margin_r       <= calc_margin(best_r, second_r);
            result_valid_r <= 1'b1;
          end else if (res.result_ready) begin
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            state_r        <= ST_IDLE;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          busy_r         <= 1'b0;
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_argmax_reader.sv
// Directed bench for score_argmax_reader: latency, ties, extremes, snapshot
// isolation, backpressure, busy rejection and mid-scan reset.
module tb_score_argmax_reader;
  import score_argmax_reader_pkg::*;

  logic clk;
  logic reset;
  logic enable;
  logic busy;
  logic signed [15:0] sc [10];

  int checks;
  int failures;

  score_argmax_reader_if res_if ();

  score_argmax_reader #(.SETTLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enableLayer3 (enable),
    .score0       (sc[0]),
    .score1       (sc[1]),
    .score2       (sc[2]),
    .score3       (sc[3]),
    .score4       (sc[4]),
    .score5       (sc[5]),
    .score6       (sc[6]),
    .score7       (sc[7]),
    .score8       (sc[8]),
    .score9       (sc[9]),
    .busy         (busy),
    .res          (res_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Produces a clean enable rising edge; returns #1 after the edge that samples it.
  task automatic start_run();
    @(negedge clk) enable = 1'b0;
    @(negedge clk) enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
  endtask

  // Advances to #1 after the edge where the result becomes valid.
  task automatic wait_to_valid();
    repeat (15) @(posedge clk);
    #1;
  endtask

  // One-cycle ready pulse; returns #1 after the accepting edge.
  task automatic do_handshake();
    @(negedge clk) res_if.result_ready = 1'b1;
    @(posedge clk);
    #1 res_if.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (res_if.result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", res_if.result_valid); end
    checks++; if (res_if.class_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", res_if.class_idx); end
    checks++; if (res_if.max_score !== 16'sd0) begin failures++; $display("FAIL reset_max got=%0d exp=0", res_if.max_score); end
    checks++; if (res_if.margin !== 16'd0) begin failures++; $display("FAIL reset_margin got=%0d exp=0", res_if.margin); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic_win();
    sc = '{-16'sd5, 16'sd12, 16'sd3, 16'sd40, 16'sd0, -16'sd100, 16'sd7, 16'sd39, 16'sd1, 16'sd2};
    start_run();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%0b exp=1", busy); end
    repeat (14) @(posedge clk);
    #1;
    checks++; if (res_if.result_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", res_if.result_valid); end
    @(posedge clk);
    #1;
    checks++; if (res_if.result_valid !== 1'b1) begin failures++; $display("FAIL basic_latency_valid got=%0b exp=1", res_if.result_valid); end
    checks++; if (res_if.class_idx !== 4'd3) begin failures++; $display("FAIL basic_idx got=%0d exp=3", res_if.class_idx); end
    checks++; if (res_if.max_score !== 16'sd40) begin failures++; $display("FAIL basic_max got=%0d exp=40", res_if.max_score); end
    checks++; if (res_if.margin !== 16'd1) begin failures++; $display("FAIL basic_margin got=%0d exp=1", res_if.margin); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (res_if.result_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_hold got=%0b exp=1", res_if.result_valid); end
    do_handshake();
    checks++; if (res_if.result_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%0b exp=0", res_if.result_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%0b exp=0", busy); end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 10; i++) sc[i] = 16'sh8000;
    start_run();
    wait_to_valid();
    checks++; if (res_if.result_valid !== 1'b1) begin failures++; $display("FAIL min_valid got=%0b exp=1", res_if.result_valid); end
    checks++; if (res_if.class_idx !== 4'd0) begin failures++; $display("FAIL min_idx got=%0d exp=0", res_if.class_idx); end
    checks++; if (res_if.max_score !== 16'sh8000) begin failures++; $display("FAIL min_max got=%0d exp=-32768", res_if.max_score); end
    checks++; if (res_if.margin !== 16'd0) begin failures++; $display("FAIL min_margin got=%0d exp=0", res_if.margin); end
    do_handshake();
    sc[9] = 16'sh7fff;
    start_run();
    wait_to_valid();
    checks++; if (res_if.class_idx !== 4'd9) begin failures++; $display("FAIL ext_idx got=%0d exp=9", res_if.class_idx); end
    checks++; if (res_if.max_score !== 16'sh7fff) begin failures++; $display("FAIL ext_max got=%0d exp=32767", res_if.max_score); end
    checks++; if (res_if.margin !== 16'hffff) begin failures++; $display("FAIL ext_margin got=%0d exp=65535", res_if.margin); end
    do_handshake();
  endtask

  task automatic test_snapshot();
    sc = '{-16'sd5, 16'sd12, 16'sd3, 16'sd40, 16'sd0, -16'sd100, 16'sd7, 16'sd39, 16'sd1, 16'sd2};
    start_run();
    repeat (7) @(posedge clk);
    #1 sc[3] = 16'sd500;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (res_if.result_valid !== 1'b1) begin failures++; $display("FAIL snap_valid got=%0b exp=1", res_if.result_valid); end
    checks++; if (res_if.class_idx !== 4'd3) begin failures++; $display("FAIL snap_idx got=%0d exp=3", res_if.class_idx); end
    checks++; if (res_if.max_score !== 16'sd40) begin failures++; $display("FAIL snap_max got=%0d exp=40", res_if.max_score); end
    checks++; if (res_if.margin !== 16'd1) begin failures++; $display("FAIL snap_margin got=%0d exp=1", res_if.margin); end
    do_handshake();
    sc[3] = 16'sd40;
  endtask

  task automatic test_backpressure();
    sc = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd77, 16'sd0, 16'sd0, 16'sd70, 16'sd0};
    start_run();
    wait_to_valid();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (res_if.result_valid !== 1'b1 || res_if.class_idx !== 4'd5 || res_if.max_score !== 16'sd77 ||
          res_if.margin !== 16'd7 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got v=%0b i=%0d m=%0d g=%0d b=%0b exp v=1 i=5 m=77 g=7 b=1",
                 c, res_if.result_valid, res_if.class_idx, res_if.max_score, res_if.margin, busy);
      end
    end
    do_handshake();
    checks++; if (res_if.result_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop got=%0b exp=0", res_if.result_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy_end got=%0b exp=0", busy); end
    checks++; if (res_if.max_score !== 16'sd77) begin failures++; $display("FAIL bp_max_kept got=%0d exp=77", res_if.max_score); end
    sc = '{-16'sd1, -16'sd2, -16'sd3, -16'sd4, -16'sd5, -16'sd6, -16'sd7, -16'sd8, -16'sd9, -16'sd10};
    repeat (2) @(posedge clk);
    start_run();
    wait_to_valid();
    checks++; if (res_if.result_valid !== 1'b1) begin failures++; $display("FAIL bp2_valid got=%0b exp=1", res_if.result_valid); end
    checks++; if (res_if.class_idx !== 4'd0) begin failures++; $display("FAIL bp2_idx got=%0d exp=0", res_if.class_idx); end
    checks++; if (res_if.max_score !== -16'sd1) begin failures++; $display("FAIL bp2_max got=%0d exp=-1", res_if.max_score); end
    checks++; if (res_if.margin !== 16'd1) begin failures++; $display("FAIL bp2_margin got=%0d exp=1", res_if.margin); end
    do_handshake();
  endtask

  task automatic test_busy_reject();
    for (int i = 0; i < 10; i++) sc[i] = 16'sd5;
    start_run();
    repeat (7) @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (res_if.result_valid !== 1'b1) begin failures++; $display("FAIL rej_valid got=%0b exp=1", res_if.result_valid); end
    checks++; if (res_if.class_idx !== 4'd0) begin failures++; $display("FAIL rej_tie_idx got=%0d exp=0", res_if.class_idx); end
    checks++; if (res_if.margin !== 16'd0) begin failures++; $display("FAIL rej_tie_margin got=%0d exp=0", res_if.margin); end
    @(negedge clk);
    res_if.result_ready = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1 res_if.result_ready = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (res_if.result_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rej_idle cycle=%0d got v=%0b b=%0b exp v=0 b=0", c, res_if.result_valid, busy);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    sc = '{-16'sd5, 16'sd12, 16'sd3, 16'sd40, 16'sd0, -16'sd100, 16'sd7, 16'sd39, 16'sd1, 16'sd2};
    start_run();
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (res_if.max_score !== 16'sd0) begin failures++; $display("FAIL rst_async_max got=%0d exp=0", res_if.max_score); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%0b exp=0", busy); end
    checks++; if (res_if.result_valid !== 1'b0 || res_if.class_idx !== 4'd0 || res_if.margin !== 16'd0) begin
      failures++; $display("FAIL rst_async_outs got v=%0b i=%0d g=%0d exp 0 0 0", res_if.result_valid, res_if.class_idx, res_if.margin);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (res_if.result_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_no_result cycle=%0d got v=%0b b=%0b exp v=0 b=0", c, res_if.result_valid, busy);
      end
    end
    sc = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd10};
    start_run();
    wait_to_valid();
    checks++; if (res_if.result_valid !== 1'b1) begin failures++; $display("FAIL rst_run_valid got=%0b exp=1", res_if.result_valid); end
    checks++; if (res_if.class_idx !== 4'd9) begin failures++; $display("FAIL rst_run_idx got=%0d exp=9", res_if.class_idx); end
    checks++; if (res_if.max_score !== 16'sd10) begin failures++; $display("FAIL rst_run_max got=%0d exp=10", res_if.max_score); end
    checks++; if (res_if.margin !== 16'd1) begin failures++; $display("FAIL rst_run_margin got=%0d exp=1", res_if.margin); end
    do_handshake();
  endtask

  // Test sequence.
  initial begin
    checks = 0;
    failures = 0;
    enable = 1'b0;
    res_if.result_ready = 1'b0;
    for (int i = 0; i < 10; i++) sc[i] = 16'sd0;
    test_reset();
    test_basic_win();
    test_extremes();
    test_snapshot();
    test_backpressure();
    test_busy_reject();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_argmax_reader.md
Name: score_argmax_reader

Overview:
- Reader end of the Top classifier output interface.
- Waits for the Layer-3 enable to rise, lets the outputs settle, then snapshots the ten signed 16-bit class scores (output0..output9).
- Scans the snapshot sequentially and reports the winning class index, its score, and the margin over the runner-up on a valid/ready handshake.
- Sits between Top and the host/bench-side result consumer.

Parameters:
- NUM_CLASSES, 10, number of score inputs scanned (fixed at 10 by the port list; the parameter sizes the counters).
- DATA_W, 16, score width, two's complement.
- SETTLE_CYCLES, 4, cycles waited after the enable rising edge before the snapshot (range 0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enableLayer3  in  1  same signal driven to Top; its rising edge starts one classification.
- score0..score9  in  16 each  signed class scores, wired to Top output0..output9.
- result_valid  out  1  result available; held until accepted.
- result_ready  in  1  consumer accepts the result when result_valid && result_ready at a clock edge.
- class_idx  out  4  index (0..9) of the maximum score.
- max_score  out  16  signed maximum score.
- margin  out  16  unsigned (max_score − second-highest score).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state IDLE, enable_q = 0.
  - All outputs 0: result_valid, class_idx, max_score, margin, busy.
  - Snapshot registers cleared.
- Edge detect: rise = enableLayer3 & ~enable_q. enable_q is registered every cycle.
- FSM states: IDLE, SETTLE, CAPTURE, SCAN, DONE.
  - IDLE: on rise, go to SETTLE with settle_cnt = 0. If SETTLE_CYCLES = 0, go directly to CAPTURE.
  - SETTLE: settle_cnt increments each cycle; when settle_cnt = SETTLE_CYCLES−1, go to CAPTURE.
  - CAPTURE: one cycle. Registers all ten scores into the snapshot, sets best = snap0 candidate, best_idx = 0, second = −32768, idx = 1. Then SCAN.
  - SCAN: one snapshot entry compared per cycle, idx 1..9.
    - If s[idx] > best (signed, strict): second ← best, best ← s[idx], best_idx ← idx.
    - Else if s[idx] > second: second ← s[idx].
    - After idx = 9, go to DONE.
  - DONE: outputs are loaded on entry. class_idx = best_idx, max_score = best, margin = best − second computed in 17 bits (result always 0..65535, fits in 16 unsigned). result_valid = 1.
    - On result_valid && result_ready: result_valid ← 0, go to IDLE. class_idx, max_score and margin keep their values until the next DONE entry.
- Latency: rise sampled at edge T gives result_valid high after edge T + SETTLE_CYCLES + NUM_CLASSES + 1. With defaults, 15 cycles.
- Ties: lowest index wins, because the comparison is strict. Equal top scores give margin = 0.
- Score inputs are sampled only in CAPTURE. Changes at any other time have no effect.
- enableLayer3 falling mid-operation: no abort.
- Rise while busy, including in DONE: ignored, not queued. A rise in the same cycle as the DONE handshake is also ignored; enable must fall and rise again.
- result_ready high outside DONE: no effect.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The result of the aborted run is never presented.

Decomposition:
- Shared package (nn_pkg):
  - DATA_W and NUM_CLASSES.
  - FSM state encoding enum.
  - Constant SCORE_MIN = 16'sh8000.
- Sub-module: score_max_update, combinational. Takes (best, second, best_idx, cand, cand_idx) and returns the next (best, second, best_idx). It is instantiated once in SCAN and unit-testable on its own.

Test Plan:
- Basic win: scores {−5, 12, 3, 40, 0, −100, 7, 39, 1, 2}, rise of enable → after 15 cycles class_idx = 3, max_score = 40, margin = 1, result_valid stays high until result_ready.
- Tie/extremes: all scores 16'sh8000 → class_idx = 0, max_score = −32768, margin = 0. Then score9 = 32767 with the rest −32768 → class_idx = 9, margin = 65535.
- Snapshot isolation: change score3 from 40 to 500 two cycles after CAPTURE → result still class_idx = 3, max_score = 40.
- Backpressure: result_ready held low 20 cycles → valid and outputs stable. Ready pulsed one cycle → valid drops next edge, busy = 0. A second rise 3 cycles later produces a fresh result.
- Busy rejection: a second enable rise during SCAN, and a rise on the handshake cycle → no second result, busy returns 0.
- Reset mid-SCAN: reset pulled low during SCAN → outputs 0 asynchronously. After release, a new rise with scores {1..10} → class_idx = 9, max_score = 10, margin = 1.
